sfifo_buf: RTL and testbench

Parametrised synchronous FIFO with integrated storage, a dual-port memory array, registered output, and an optional first-word-fall-through (FWFT) mode. It adds fill level, almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow flags. It sits between peripheral data producers and consumers, such as the audio/I2S and UART paths, and replaces ad-hoc pointer logic around bare FIFO memories.

---
 rtl/sfifo_buf.sv | 155 +++++++++++++++
 tb/tb_sfifo_buf.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sfifo_buf.sv
// Synchronous FIFO with dual-port storage, registered output and optional
// first-word-fall-through; tracks fill level, thresholds and sticky error flags.
module sfifo_buf #(
    parameter int BW       = 32,
    parameter int LGFLEN   = 4,
    parameter int OPT_FWFT = 0,
    parameter int AF_LEVEL = (1 << LGFLEN) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    output logic              o_full,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int              D     = 1 << LGFLEN;
    localparam logic [LGFLEN:0] DEPTH = D[LGFLEN:0];
    localparam logic [LGFLEN:0] AF_TH = AF_LEVEL[LGFLEN:0];
    localparam logic [LGFLEN:0] AE_TH = AE_LEVEL[LGFLEN:0];

    logic [BW-1:0]     mem [0:D-1];
    logic [LGFLEN-1:0] wr_ptr;
    logic [LGFLEN-1:0] rd_ptr;
    logic [LGFLEN:0]   fill;
    logic [BW-1:0]     data_q;
    logic              overflow;
    logic              underflow;
    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              wr_ok;
    logic              mem_wr;
    logic              mem_rd;

    // Flush masks both requests so the flush cycle never touches state or flags.
    assign full  = (fill == DEPTH);
    assign rd_ok = i_rd && !empty && !i_flush;
    assign wr_ok = i_wr && (!full || rd_ok) && !i_flush;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fill <= '0;
        end else if (i_flush) begin
            fill <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   fill <= fill + (LGFLEN+1)'(1);
                2'b01:   fill <= fill - (LGFLEN+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (i_flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (i_wr && !wr_ok)
                overflow <= 1'b1;
            if (i_rd && empty)
                underflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (mem_wr)
                wr_ptr <= wr_ptr + LGFLEN'(1);
            if (mem_rd)
                rd_ptr <= rd_ptr + LGFLEN'(1);
        end
    end

    // Storage carries no reset; contents are qualified by the pointers.
    always_ff @(posedge i_clk) begin
        if (mem_wr)
            mem[wr_ptr] <= i_data;
    end

    generate
        if (OPT_FWFT != 0) begin : g_fwft
            logic out_valid;
            logic mem_empty;
            logic load;
            logic bypass;

            // The output register holds the head; fill counts it, so the
            // memory holds fill - out_valid entries.
            assign mem_empty = (fill == {{LGFLEN{1'b0}}, out_valid});
            assign load      = !out_valid || rd_ok;
            assign bypass    = load && mem_empty && wr_ok;
            assign mem_rd    = load && !mem_empty && !i_flush;
            assign mem_wr    = wr_ok && !bypass;
            assign empty     = !out_valid;

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    out_valid <= 1'b0;
                    data_q    <= '0;
                end else if (i_flush) begin
                    out_valid <= 1'b0;
                end else if (mem_rd) begin
                    out_valid <= 1'b1;
                    data_q    <= mem[rd_ptr];
                end else if (bypass) begin
                    out_valid <= 1'b1;
                    data_q    <= i_data;
                end else if (rd_ok) begin
                    out_valid <= 1'b0;
                end
            end
        end else begin : g_std
            assign mem_rd = rd_ok;
            assign mem_wr = wr_ok;
            assign empty  = (fill == '0);

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n)
                    data_q <= '0;
                else if (rd_ok)
                    data_q <= mem[rd_ptr];
            end
        end
    endgenerate

    assign o_full         = full;
    assign o_empty        = empty;
    assign o_fill         = fill;
    assign o_data         = data_q;
    assign o_almost_full  = (fill >= AF_TH);
    assign o_almost_empty = (fill <= AE_TH);
    assign o_overflow     = overflow;
    assign o_underflow    = underflow;

endmodule

// File: tb/tb_sfifo_buf.sv
// Bench for sfifo_buf: a standard-read and an FWFT instance share stimulus and are
// compared each cycle against a queue model, plus hand-computed literal checks.
module tb_sfifo_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] din = '0;

    logic        full0, empty0, af0, ae0, ovf0, unf0;
    logic        full1, empty1, af1, ae1, ovf1, unf1;
    logic [31:0] data0, data1;
    logic [4:0]  fill0, fill1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sfifo_buf #(.BW(32), .LGFLEN(4), .OPT_FWFT(0), .AF_LEVEL(12), .AE_LEVEL(3)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_wr(wr), .i_data(din),
        .o_full(full0), .i_rd(rd), .o_data(data0), .o_empty(empty0), .o_fill(fill0),
        .o_almost_full(af0), .o_almost_empty(ae0), .o_overflow(ovf0), .o_underflow(unf0));

    sfifo_buf #(.BW(32), .LGFLEN(4), .OPT_FWFT(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_wr(wr), .i_data(din),
        .o_full(full1), .i_rd(rd), .o_data(data1), .o_empty(empty1), .o_fill(fill1),
        .o_almost_full(af1), .o_almost_empty(ae1), .o_overflow(ovf1), .o_underflow(unf1));

    // Model: the FIFO contents as a queue, sticky flags, last popped word.
    logic [31:0] q[$];
    bit          m_ovf, m_unf, r_ok, w_ok;
    logic [31:0] m0_data;
    int          n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m0_data = '0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            r_ok = rd && (q.size() > 0);
            w_ok = wr && ((q.size() < 16) || r_ok);
            if (wr && !w_ok) m_ovf = 1'b1;
            if (rd && q.size() == 0) m_unf = 1'b1;
            if (r_ok) m0_data = q.pop_front();
            if (w_ok) q.push_back(din);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n = q.size();
            check("fill0", 32'(fill0), n);
            check("fill1", 32'(fill1), n);
            check("empty0", 32'(empty0), 32'(n == 0));
            check("empty1", 32'(empty1), 32'(n == 0));
            check("full0", 32'(full0), 32'(n == 16));
            check("full1", 32'(full1), 32'(n == 16));
            check("af0", 32'(af0), 32'(n >= 12));
            check("ae0", 32'(ae0), 32'(n <= 3));
            check("af1", 32'(af1), 32'(n >= 15));
            check("ae1", 32'(ae1), 32'(n <= 1));
            check("ovf0", 32'(ovf0), 32'(m_ovf));
            check("unf0", 32'(unf0), 32'(m_unf));
            check("ovf1", 32'(ovf1), 32'(m_ovf));
            check("unf1", 32'(unf1), 32'(m_unf));
            check("data0", data0, m0_data);
            if (n > 0) check("data1_head", data1, q[0]);
        end
    end

    // Inputs change just after a falling edge and hold through the next rising edge.
    task automatic step(input logic w, input logic r, input logic f, input logic [31:0] d);
        wr = w; rd = r; flush = f; din = d;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; flush = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data0"}, data0, 32'h0);
        check({tag, "_data1"}, data1, 32'h0);
        check({tag, "_empty"}, 32'({empty0, empty1}), 32'h3);
        check({tag, "_full"}, 32'({full0, full1}), 32'h0);
        check({tag, "_fill"}, 32'({fill0, fill1}), 32'h0);
        check({tag, "_af"}, 32'({af0, af1}), 32'h0);
        check({tag, "_ae"}, 32'({ae0, ae1}), 32'h3);
        check({tag, "_flags"}, 32'({ovf0, unf0, ovf1, unf1}), 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Fill to capacity with 0x11..0x20.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 32'h11 + 32'(i));
        check("lit_fill16", 32'(fill0), 32'd16);
        check("lit_full16", 32'(full1), 32'd1);
        check("lit_head1", data1, 32'h11);

        // Dropped write, then simultaneous read+write at full.
        step(1'b1, 1'b0, 1'b0, 32'hDEAD);
        check("lit_ovf", 32'(ovf0), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h21);
        check("lit_rw_full_data0", data0, 32'h11);
        check("lit_rw_full_fill", 32'(fill1), 32'd16);
        check("lit_rw_full_head1", data1, 32'h12);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_drain_data0", data0, 32'h21);
        check("lit_drain_empty", 32'({empty0, empty1}), 32'h3);

        // Underflow, then flush clears flags.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_unf", 32'(unf0), 32'd1);
        check("lit_unf_data0", data0, 32'h21);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("lit_flush_flags", 32'({ovf0, unf0, ovf1, unf1}), 32'h0);

        // Sustained streaming across pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
        for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 1'b0, 32'h103 + 32'(i));
        check("lit_stream_fill", 32'(fill0), 32'd3);
        check("lit_stream_data0", data0, 32'h100 + 32'd47);
        check("lit_stream_head1", data1, 32'h100 + 32'd48);
        // Simultaneous read+write at fill 1 in FWFT: new word falls through.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h77);
        check("lit_fwft_rw1_head", data1, 32'h77);
        check("lit_fwft_rw1_empty", 32'(empty1), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);

        // First-word fall-through of a single word.
        step(1'b1, 1'b0, 1'b0, 32'hA5);
        check("lit_fwft_data", data1, 32'hA5);
        check("lit_fwft_empty", 32'(empty1), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_fwft_empty_after", 32'(empty1), 32'd1);
        check("lit_std_data_a5", data0, 32'hA5);

        // Threshold ramp on the AF=12/AE=3 instance.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h200 + 32'(i));
            if (i == 3)  check("lit_ae_at3", 32'(ae0), 32'd1);
            if (i == 4)  check("lit_ae_at4", 32'(ae0), 32'd0);
            if (i == 11) check("lit_af_at11", 32'(af0), 32'd0);
            if (i == 12) check("lit_af_at12", 32'(af0), 32'd1);
        end
        // Flush wins over requests on a full FIFO and sets no flags.
        step(1'b1, 1'b1, 1'b1, 32'hBAD);
        check("lit_flush_full_fill", 32'(fill0), 32'd0);
        check("lit_flush_full_flags", 32'({ovf0, unf0, ovf1, unf1}), 32'h0);

        // Asynchronous reset mid-ramp at fill 9.
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0, 32'h300 + 32'(i));
        check("lit_fill9", 32'(fill1), 32'd9);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h55);
        check("lit_after_reset_head", data1, 32'h55);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_after_reset_data0", data0, 32'h55);
        @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
